// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor D = A - B - Bin, one lookahead nibble per clock.
// Optional SUB_OVERFLOW_FLAG_EN adds a signed-overflow output ovf.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
`ifdef SUB_OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bout_q, bout_d, zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [CntW+1:0]  lsb;
    logic [3:0]       g, p, sum;
    logic [4:0]       c;

    // Subtraction as A + ~B + carry, with carry = ~borrow.
    always_comb begin
        lsb  = {cnt_q, 2'b00};
        g    = a_q[lsb +: 4] & ~b_q[lsb +: 4];
        p    = a_q[lsb +: 4] ^ ~b_q[lsb +: 4];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = ~Bin;
                    cnt_d   = '0;
                    d_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                d_d[lsb +: 4] = sum;
                carry_d       = c[4];
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StDone;
                    bout_d  = ~c[4];
                    zero_d  = (d_d == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign D         = d_q;
    assign B_out     = bout_q;
    assign zero      = zero_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor; arithmetic reference model, random stimulus.
// Honours SUB_OVERFLOW_FLAG_EN when defined.
module tb_nibble_serial_subtractor;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         B_out;
    logic         zero;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .B_out     (B_out),
`ifdef SUB_OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   hold_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t   e;
        longint diff;
        diff = longint'(a) - longint'(b) - longint'(bin);
        e.d  = W'(diff);
        e.bo = (longint'(a) < longint'(b) + longint'(bin));
        e.z  = (e.d == '0);
        e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready stuck at %b required 1", in_ready);
            return;
        end
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        e        = model(a, b, bin);
        e.acc    = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        Bin      = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0 || out_valid) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    // Monitor: checks latency, stability under backpressure, and result on handshake.
    initial begin
        logic         ov_prev;
        logic [W-1:0] held_d;
        logic         held_b, held_z;
        exp_t         e;
        out_ready = 1'b0;
        ov_prev   = 1'b0;
        held_d    = '0;
        held_b    = 1'b0;
        held_z    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_prev   = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: got 1 required 0");
                    out_ready = 1'b1;
                end else begin
                    if (!ov_prev) begin
                        chk("latency", W'(cyc - q[0].acc), W'(N));
                        held_d = D;
                        held_b = B_out;
                        held_z = zero;
                    end else begin
                        chk("hold_D", D, held_d);
                        chk("hold_B_out", W'(B_out), W'(held_b));
                        chk("hold_zero", W'(zero), W'(held_z));
                        chk("hold_in_ready", W'(in_ready), W'(0));
                    end
                    if (hold_cnt > 0) begin
                        out_ready = 1'b0;
                        hold_cnt--;
                    end else begin
                        out_ready = ($urandom % 3) != 0;
                    end
                    if (out_ready) begin
                        e = q.pop_front();
                        chk("D", D, e.d);
                        chk("B_out", W'(B_out), W'(e.bo));
                        chk("zero", W'(zero), W'(e.z));
`ifdef SUB_OVERFLOW_FLAG_EN
                        chk("ovf", W'(ovf), W'(e.ov));
`endif
                    end
                end
            end else begin
                out_ready = 1'($urandom);
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Bin      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_D", D, '0);
        chk("rst_B_out", W'(B_out), W'(0));
        chk("rst_zero", W'(zero), W'(0));
        rst = 1'b0;

        // Directed cases
        issue(16'h1234, 16'h0034, 1'b0);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h00FF, 16'h00FE, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        issue(16'h0000, 16'hFFFF, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h0005, 16'h0003, 1'b0);
        issue(16'h7FFF, 16'hFFFF, 1'b0);
        drain();

        // Backpressure with ignored operands during RUN/DONE
        hold_cnt = 5;
        issue(16'h4321, 16'h1234, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            A        = 16'hAAAA;
            B        = 16'h0001;
            chk("busy_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        issue(16'h0100, 16'h0001, 1'b0);
        drain();

        // Reset two cycles into RUN discards the pending result
        issue(16'h1111, 16'h0222, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_D", D, '0);
        chk("midrst_in_ready", W'(in_ready), W'(1));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(16'h0005, 16'h0003, 1'b0);
        drain();

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            case ($urandom % 4)
                0:       b = a;
                1:       b = a + W'($urandom % 3);
                default: b = W'($urandom);
            endcase
            if ($urandom % 8 == 0) hold_cnt = int'($urandom % 4);
            issue(a, b, 1'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle WIDTH-bit subtractor computing D = A - B - Bin, one 4-bit nibble per clock through a lookahead nibble slice with a registered borrow chain.
- Inverse-direction companion to the team's 4-bit carry lookahead adder.
- Serves the ALU datapath wherever wide subtraction or compare is needed without a full-width carry chain.
- Valid/ready handshake on both input and output sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands A, B, Bin are valid
in_ready  output  1  block can accept operands
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
Bin  input  1  borrow in
out_valid  output  1  result D, B_out, zero are valid
out_ready  input  1  consumer accepts result
D  output  WIDTH  difference
B_out  output  1  borrow out (1 when A < B + Bin, unsigned)
zero  output  1  1 when D == 0

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, D=0, B_out=0, zero=0, internal carry=0, nibble counter=0.
- Constant: N = WIDTH/4.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A and B, set carry = ~Bin, counter = 0, clear D to 0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle on nibble i = counter: {c, D[4i+3:4i]} <= A[4i+3:4i] + ~B[4i+3:4i] + carry; carry <= c; counter++.
  - After nibble N-1 is written: go to DONE, B_out = ~c, zero = (full D == 0).
- DONE:
  - out_valid=1; D, B_out and zero are held stable until out_ready.
  - On out_valid&&out_ready: out_valid=0 and go to IDLE. in_ready returns to 1 on the following cycle; no same-cycle accept while in DONE.
- Latency: operands accepted at edge T give out_valid high after edge T+N (4 cycles for WIDTH=16).
- Throughput: one result per N+2 cycles minimum.
- Inputs A, B, Bin are ignored while not in IDLE; changing them mid-RUN has no effect.
- D is internal working state during RUN; it is meaningful only while out_valid=1.
- Modulo arithmetic: D wraps modulo 2^WIDTH, e.g. 0 - 1 = all ones with B_out=1.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the pending result is discarded.
- out_ready high while out_valid=0 has no effect.
- in_valid and out_ready high in the same DONE cycle: only the output handshake completes; the input is not accepted.

Optional Feature:
SUB_OVERFLOW_FLAG_EN
- When defined:
  - Extra output port ovf (1 bit): signed two's-complement overflow, ovf = (A[W-1] != B[W-1]) && (D[W-1] != A[W-1]), using the latched A and B.
  - ovf is valid with out_valid, held through DONE, and reset to 0.
- When undefined: no ovf port and no ovf logic; all other behaviour is identical.

Test Plan:
1. WIDTH=16: A=0x1234, B=0x0034, Bin=0 -> D=0x1200, B_out=0, zero=0; out_valid rises exactly 4 cycles after accept.
2. A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, B_out=1, zero=0 (wrap-around).
3. A=0x00FF, B=0x00FE, Bin=1 -> D=0x0000, B_out=0, zero=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> D, B_out and out_valid stay stable; in_valid pulsed with A=0xAAAA during RUN/DONE is ignored (in_ready=0), and the next accepted operation yields its own correct result.
5. Reset mid-operation: assert rst 2 cycles into RUN -> out_valid=0, D=0, in_ready=1 immediately; a new op A=0x0005, B=0x0003 -> D=0x0002, B_out=0.
6. With SUB_OVERFLOW_FLAG_EN: A=0x8000, B=0x0001 -> D=0x7FFF, ovf=1, B_out=0; A=0x0005, B=0x0003 -> D=0x0002, ovf=0.
